// File: rtl/inst_fetch.sv
// inst_fetch: initiator side of the instruction-ROM read interface.
//
// Owns the program counter, issues zero-latency reads to a combinational
// instruction ROM, and queues each returned word with its PC in a small FIFO.
// The FIFO head is offered to decode over a valid/ready handshake. Branch,
// jump and trap redirects flush the queue. A pipeline hold suspends new
// fetches but lets the queue drain.
//
// Parameters:
//   RESET_PC     PC loaded at reset (word aligned)
//   DEPTH        fetch FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous reset, active-high
//   rom_en       ROM read enable (a fetch happens this cycle)
//   rom_addr     ROM byte address, always equal to the current PC
//   rom_inst_i   ROM read data, valid in the same cycle as rom_en
//   hold_i       pipeline hold, suppresses new fetches
//   jump_i       redirect request (branch/jump/trap)
//   jump_addr_i  redirect target, bits [1:0] ignored
//   inst_valid_o FIFO head valid
//   inst_ready_i decode accepts the head
//   inst_o       head instruction (0 when empty)
//   pc_o         head PC (0 when empty)
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst_i,
  input  logic        hold_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   pc_q,    pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] rptr_q,  rptr_d;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          push;
  logic          pop;
  logic          not_empty;

  assign not_empty = (count_q != '0);

  // The full test ignores a same-cycle pop so that inst_ready_i never
  // reaches the ROM enable / address path.
  assign rom_en   = !rst && !jump_i && !hold_i && (count_q < FULL_CNT);
  assign rom_addr = pc_q;

  assign inst_valid_o = !rst && not_empty && !jump_i;
  assign inst_o       = (!rst && not_empty) ? inst_mem_q[rptr_q] : '0;
  assign pc_o         = (!rst && not_empty) ? pc_mem_q[rptr_q]   : '0;

  assign push = rom_en;
  assign pop  = inst_valid_o && inst_ready_i;

  // Next-state: a redirect overrides normal push/pop bookkeeping; since
  // rom_en and inst_valid_o are both low during jump_i, push and pop are
  // already zero in that cycle.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (jump_i) begin
      pc_d    = jump_addr_i & 32'hFFFF_FFFC;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wptr_q] <= rom_inst_i;
      pc_mem_q[wptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a ROM model returns 32'h1000_0000 + word
// index; directed phases drive reset, backpressure, redirect, hold, PC wrap
// and reset-with-jump, and push the PCs they expect decode to receive. A
// separate monitor pops and compares every accepted head entry.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst_i;
  logic        hold_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] exp_q [$];

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_inst_i   (rom_inst_i),
    .hold_i       (hold_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  always_comb rom_inst_i = rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: invariant plus scoreboard pop on every accepted head entry.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && dut.count_q == '0) begin
      chk("empty_implies_not_valid", {31'b0, inst_valid_o}, 32'd0);
      assert (!inst_valid_o);
    end
    if (inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", pc_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", pc_o, e);
        chk("pop_inst", inst_o, rom_word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; hold_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0; inst_ready_i = 1'b1;

    // Reset state
    cyc();
    neg();
    chk("rst_rom_en",   {31'b0, rom_en},       32'd0);
    chk("rst_valid",    {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst",     inst_o,                32'd0);
    chk("rst_pc",       pc_o,                  32'd0);
    chk("rst_rom_addr", rom_addr,              32'd0);
    cyc();
    rst = 1'b0;

    // Streaming at one instruction per cycle
    for (int unsigned i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int unsigned i = 0; i < 6; i++) begin
      neg();
      chk("stream_rom_en", {31'b0, rom_en}, 32'd1);
      chk("stream_addr", rom_addr, 32'(i * 4));
      if (i == 0) chk("stream_first_valid", {31'b0, inst_valid_o}, 32'd0);
      cyc();
    end
    rst = 1'b1;
    inst_ready_i = 1'b0;
    cyc();
    rst = 1'b0;

    // Backpressure: two fetches fill the FIFO, then fetch stalls at pc 8
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    neg(); chk("bp_en0", {31'b0, rom_en}, 32'd1); chk("bp_addr0", rom_addr, 32'h0); cyc();
    neg(); chk("bp_en1", {31'b0, rom_en}, 32'd1); chk("bp_addr1", rom_addr, 32'h4); cyc();
    for (int unsigned k = 0; k < 3; k++) begin
      neg();
      chk("bp_full_en", {31'b0, rom_en}, 32'd0);
      chk("bp_full_addr", rom_addr, 32'h8);
      chk("bp_full_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("bp_full_pc", pc_o, 32'h0);
      cyc();
    end
    inst_ready_i = 1'b1;
    neg(); chk("bp_full_pop_no_fetch", {31'b0, rom_en}, 32'd0); chk("bp_addr_hold", rom_addr, 32'h8); cyc();
    neg(); chk("bp_resume_en", {31'b0, rom_en}, 32'd1); chk("bp_resume_addr", rom_addr, 32'h8); cyc();
    inst_ready_i = 1'b0;
    neg(); chk("bp_fill_addr", rom_addr, 32'hC); chk("bp_head_pc", pc_o, 32'h8); cyc();

    // Redirect with pc 8 and 12 queued; ready high must not pop
    jump_i = 1'b1; jump_addr_i = 32'h0000_0103; inst_ready_i = 1'b1;
    neg();
    chk("jmp_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("jmp_rom_en", {31'b0, rom_en}, 32'd0);
    cyc();
    jump_i = 1'b0; inst_ready_i = 1'b0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    neg();
    chk("jmp_tgt_en", {31'b0, rom_en}, 32'd1);
    chk("jmp_tgt_addr", rom_addr, 32'h100);
    chk("jmp_flushed", {31'b0, inst_valid_o}, 32'd0);
    cyc();
    neg();
    chk("jmp_head_pc", pc_o, 32'h100);
    chk("jmp_head_inst", inst_o, 32'h1000_0040);
    chk("jmp_next_addr", rom_addr, 32'h104);
    cyc();

    // Hold for 3 cycles: queue drains, pc frozen at 0x108
    hold_i = 1'b1; inst_ready_i = 1'b1;
    exp_q.push_back(32'h108);
    for (int unsigned k = 0; k < 3; k++) begin
      neg();
      chk("hold_en", {31'b0, rom_en}, 32'd0);
      chk("hold_addr", rom_addr, 32'h108);
      if (k == 2) chk("hold_drained", {31'b0, inst_valid_o}, 32'd0);
      cyc();
    end
    hold_i = 1'b0;
    neg(); chk("unhold_en", {31'b0, rom_en}, 32'd1); chk("unhold_addr", rom_addr, 32'h108); cyc();
    neg(); chk("unhold_head", pc_o, 32'h108); chk("unhold_next", rom_addr, 32'h10C); cyc();

    // Redirect to the top word; fetch after it wraps to 0
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    neg(); chk("wrap_jmp_valid", {31'b0, inst_valid_o}, 32'd0); cyc();
    jump_i = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    neg(); chk("wrap_top_addr", rom_addr, 32'hFFFF_FFFC); chk("wrap_top_en", {31'b0, rom_en}, 32'd1); cyc();
    neg(); chk("wrap_zero_addr", rom_addr, 32'h0); chk("wrap_head_inst", inst_o, 32'h4FFF_FFFF); cyc();

    // Reset together with jump: reset wins, jump ignored
    rst = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h0000_0200;
    neg();
    chk("rj_en", {31'b0, rom_en}, 32'd0);
    chk("rj_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rj_addr", rom_addr, 32'h4);
    chk("rj_pc_o", pc_o, 32'h0);
    cyc();
    rst = 1'b0; jump_i = 1'b0;
    exp_q.push_back(32'h0);
    neg();
    chk("rj_restart_addr", rom_addr, 32'h0);
    chk("rj_restart_en", {31'b0, rom_en}, 32'd1);
    chk("rj_empty", {31'b0, inst_valid_o}, 32'd0);
    cyc();
    neg(); chk("rj_head_pc", pc_o, 32'h0); chk("rj_head_inst", inst_o, 32'h1000_0000); cyc();

    rst = 1'b1;
    cyc();
    cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
